fifo_frame_packer: RTL and testbench
====================================

Name: fifo_frame_packer

Overview:
Sits directly downstream of the read port of fifo_async_circular, in the read-clock domain. It pops words from the FIFO into an internal buffer and closes a frame on a length limit or an idle timeout. Each frame goes out on a valid/ready stream as SOF, LEN, payload, CHK, and feeds the serial TX or DMA stage.

Parameters:
WIDTH, 8, word width; must match the FIFO WIDTH.
MAX_LEN, 16, maximum payload words per frame; 1 <= MAX_LEN <= 2^WIDTH-1.
TIMEOUT, 32, consecutive FIFO-empty cycles that close a non-empty frame; >= 1.
SOF, 8'hA5, start-of-frame word.

Ports:
clk  in  1  single clock; the FIFO read_clk domain.
nrst_in  in  1  reset, asynchronous, active-low.
fifo_empty_in  in  1  FIFO empty_out.
fifo_data_in  in  WIDTH  FIFO data_read_out; show-ahead, valid whenever fifo_empty_in=0.
fifo_read_out  out  1  FIFO read_in; pops one word per cycle at the clk edge.
m_data_out  out  WIDTH  stream data.
m_valid_out  out  1  stream valid.
m_ready_in  in  1  stream ready.
busy_out  out  1  high in any state other than FILL.
frame_count_out  out  16  completed frames; wraps modulo 2^16.

Behaviour:
- Reset: async assert of nrst_in=0 forces the following immediately.
  - state=FILL, buffer count=0, idle counter=0.
  - fifo_read_out=0, m_valid_out=0, m_data_out=0, busy_out=0, frame_count_out=0.
  - Reset mid-frame discards all buffered words. The words already popped are lost; words still in the FIFO are untouched.
- States: FILL, SOF, LEN, PAY, CHK.
- FILL:
  - fifo_read_out is combinational: high iff state=FILL, fifo_empty_in=0 and count<MAX_LEN.
  - On each pop edge: buf[count]<=fifo_data_in, count++, idle<=0.
  - When count>0 and no pop: idle++, saturating.
  - When count=0: idle is held at 0.
  - Close conditions: count reaches MAX_LEN (takes effect the edge after the last pop), or count>0 and idle reaches TIMEOUT. Either moves FILL->SOF.
  - An empty FIFO with count=0 never closes; there are no zero-length frames.
  - TIMEOUT-1 empty cycles between words keep the words in the same frame.
- Send states:
  - fifo_read_out=0 throughout.
  - m_valid_out and m_data_out are registered and present one word at a time.
  - Transfer occurs on a clk edge with m_valid_out=1 and m_ready_in=1.
  - While m_valid_out=1 and m_ready_in=0, m_data_out is held stable.
  - m_valid_out is never dropped without a transfer.
- Send sequence:
  - SOF: emit SOF, then ->LEN.
  - LEN: emit count (zero-extended to WIDTH), then ->PAY.
  - PAY: emit buf[0..count-1] in pop order, then ->CHK.
  - CHK: emit the XOR of the LEN word and all payload words.
- Back-to-back words: with m_ready_in held high, one word transfers per cycle with no bubbles. The full frame takes count+3 cycles.
- Frame completion, on the CHK transfer edge:
  - frame_count_out++.
  - count<=0, idle<=0, state->FILL.
  - m_valid_out falls in the same edge unless a new frame is already closing; it cannot be, since FILL takes at least one pop.
- Popping resumes the cycle after returning to FILL. Words arriving during a send wait in the FIFO.
- Simultaneous events: in FILL, a pop on the same edge that idle would reach TIMEOUT takes priority. idle resets and the frame stays open.

Test Plan:
1. Reset, write 0x11,0x22,0x33 into the FIFO, m_ready_in=1, then leave the FIFO empty -> after 32 idle cycles the stream is A5,03,11,22,33,03. frame_count_out=1.
2. Write 0x01..0x10 continuously -> frame A5,10,01..10,00 closes on MAX_LEN with no timeout wait. A 17th word 0x55 stays in the FIFO until CHK transfers, then starts frame 2.
3. Repeat scenario 1 with m_ready_in toggling 1/0 every cycle -> identical word sequence. m_data_out is stable on every valid&&!ready cycle, and no word is duplicated or dropped.
4. FIFO kept empty for 1000 cycles after reset -> fifo_read_out=0, m_valid_out=0, busy_out=0 throughout.
5. Words 0xAA, then 31 empty cycles, then 0xBB -> a single frame A5,02,AA,BB,13. With 32 empty cycles instead, the result is two frames (A5,01,AA,AB) and (A5,01,BB,BA).
6. Assert nrst_in low during PAY of scenario 2 -> m_valid_out=0 and busy_out=0 immediately, without waiting for clk. After release plus a fresh write of 0x77 and timeout, the output is A5,01,77,76 and frame_count_out=1.

Source files
------------

// File: rtl/fifo_frame_packer.sv
// Frame packer behind an async FIFO read port: buffers popped words and
// emits SOF, LEN, payload, CHK frames on a valid/ready stream.
module fifo_frame_packer #(
  parameter int               WIDTH   = 8,
  parameter int               MAX_LEN = 16,
  parameter int               TIMEOUT = 32,
  parameter logic [WIDTH-1:0] SOF     = 8'hA5
) (
  input  logic             clk,
  input  logic             nrst_in,
  input  logic             fifo_empty_in,
  input  logic [WIDTH-1:0] fifo_data_in,
  output logic             fifo_read_out,
  output logic [WIDTH-1:0] m_data_out,
  output logic             m_valid_out,
  input  logic             m_ready_in,
  output logic             busy_out,
  output logic [15:0]      frame_count_out
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_SOF,
    S_LEN,
    S_PAY,
    S_CHK
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [CW-1:0]    idx;
  logic [IW-1:0]    idle;
  logic [WIDTH-1:0] csum;
  logic [WIDTH-1:0] mem [MAX_LEN];

  logic             pop;
  logic             full;
  logic             timed;
  logic [WIDTH-1:0] len_word;

  assign pop = (state == S_FILL) && !fifo_empty_in
            && (count < CW'(MAX_LEN));
  assign full = (count == CW'(MAX_LEN));
  // A pop on the timeout edge wins and keeps the frame open.
  assign timed = !pop && (count != '0)
              && (idle == IW'(TIMEOUT - 1));
  assign len_word = WIDTH'(count);

  assign fifo_read_out = pop;
  assign busy_out = (state != S_FILL);

  always_ff @(posedge clk) begin
    if (pop) begin
      mem[count[AW-1:0]] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state           <= S_FILL;
      count           <= '0;
      idx             <= '0;
      idle            <= '0;
      csum            <= '0;
      m_valid_out     <= 1'b0;
      m_data_out      <= '0;
      frame_count_out <= '0;
    end else begin
      unique case (state)
        S_FILL: begin
          if (full || timed) begin
            state       <= S_SOF;
            m_valid_out <= 1'b1;
            m_data_out  <= SOF;
            csum        <= len_word;
          end else if (pop) begin
            count <= count + CW'(1);
            idle  <= '0;
          end else if (count != '0) begin
            if (idle != IW'(TIMEOUT)) begin
              idle <= idle + IW'(1);
            end
          end else begin
            idle <= '0;
          end
        end
        S_SOF: begin
          if (m_ready_in) begin
            m_data_out <= len_word;
            state      <= S_LEN;
          end
        end
        S_LEN: begin
          if (m_ready_in) begin
            m_data_out <= mem[0];
            idx        <= CW'(1);
            state      <= S_PAY;
          end
        end
        S_PAY: begin
          if (m_ready_in) begin
            csum <= csum ^ m_data_out;
            if (idx == count) begin
              m_data_out <= csum ^ m_data_out;
              state      <= S_CHK;
            end else begin
              m_data_out <= mem[idx[AW-1:0]];
              idx        <= idx + CW'(1);
            end
          end
        end
        S_CHK: begin
          if (m_ready_in) begin
            m_valid_out     <= 1'b0;
            m_data_out      <= '0;
            frame_count_out <= frame_count_out + 16'd1;
            count           <= '0;
            idle            <= '0;
            state           <= S_FILL;
          end
        end
        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Bench for fifo_frame_packer: queue-based FIFO and frame model,
// directed scenarios plus randomized bursts, gaps and backpressure.
module tb_fifo_frame_packer;

  localparam int          WIDTH   = 8;
  localparam int          MAX_LEN = 16;
  localparam int          TIMEOUT = 32;
  localparam logic [7:0]  SOF     = 8'hA5;

  logic        clk = 1'b0;
  logic        nrst_in;
  logic        fifo_empty_in;
  logic [7:0]  fifo_data_in;
  logic        fifo_read_out;
  logic [7:0]  m_data_out;
  logic        m_valid_out;
  logic        m_ready_in;
  logic        busy_out;
  logic [15:0] frame_count_out;

  always #5 clk = ~clk;

  fifo_frame_packer #(
    .WIDTH(WIDTH),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT(TIMEOUT),
    .SOF(SOF)
  ) dut (
    .clk(clk),
    .nrst_in(nrst_in),
    .fifo_empty_in(fifo_empty_in),
    .fifo_data_in(fifo_data_in),
    .fifo_read_out(fifo_read_out),
    .m_data_out(m_data_out),
    .m_valid_out(m_valid_out),
    .m_ready_in(m_ready_in),
    .busy_out(busy_out),
    .frame_count_out(frame_count_out)
  );

  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_pop = 0;
  int sof_gap = 0;
  int fifo_at_sof = 0;
  int n_xfer = 0;
  int exp_frames = 0;
  int rdy_mode = 0;
  bit pop_pending = 0;
  bit prev_stall = 0;
  bit meas = 0;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: SOF, length, words, XOR of length and words.
  function automatic void model_frame(input logic [7:0] w[$]);
    logic [7:0] x;
    exp_q.push_back({1'b0, SOF});
    x = 8'(w.size());
    exp_q.push_back({1'b0, x});
    foreach (w[i]) begin
      exp_q.push_back({1'b0, w[i]});
      x = x ^ w[i];
    end
    exp_q.push_back({1'b0, x});
    exp_frames++;
  endfunction

  // A contiguous burst splits into MAX_LEN chunks plus a timed-out tail.
  function automatic void model_burst(input logic [7:0] w[$]);
    logic [7:0] c[$];
    foreach (w[i]) begin
      c.push_back(w[i]);
      if (c.size() == MAX_LEN) begin
        model_frame(c);
        c.delete();
      end
    end
    if (c.size() > 0) model_frame(c);
  endfunction

  function automatic void push_words(input logic [7:0] w[$]);
    foreach (w[i]) fifo_q.push_back(w[i]);
  endfunction

  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty_in = (fifo_q.size() == 0);
    fifo_data_in = fifo_empty_in ? 8'h00 : fifo_q[0];
    case (rdy_mode)
      0: m_ready_in = 1'b1;
      1: m_ready_in = ~m_ready_in;
      default: m_ready_in = 1'($urandom_range(0, 1));
    endcase
    #1;
    pop_pending = fifo_read_out;
    if (pop_pending) last_pop = cyc;
    if (prev_stall) begin
      chk("hold_valid", 32'(m_valid_out), 32'd1);
      chk("hold_data", 32'(m_data_out), 32'(prev_data));
    end
    if (meas && m_valid_out) begin
      sof_gap = cyc - last_pop;
      fifo_at_sof = fifo_q.size();
      meas = 0;
    end
    if (m_valid_out && m_ready_in) begin
      e = 9'h100;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("stream", 32'({1'b0, m_data_out}), 32'(e));
      n_xfer++;
    end
    prev_stall = m_valid_out && !m_ready_in;
    prev_data = m_data_out;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy_out || fifo_q.size() > 0)
           && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy_out), 32'd0);
    chk({tag, "_frames"}, 32'(frame_count_out), 32'(exp_frames));
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_frames = 0;
    pop_pending = 0;
    prev_stall = 0;
  endtask

  initial begin
    logic [7:0] w[$];
    logic [7:0] a;
    logic [7:0] b;
    int gap;
    int n0;
    int k;

    nrst_in = 1'b0;
    fifo_empty_in = 1'b1;
    fifo_data_in = 8'h00;
    m_ready_in = 1'b0;
    clear_model();
    repeat (2) tick();
    nrst_in = 1'b1;
    chk("rst_read", 32'(fifo_read_out), 32'd0);
    chk("rst_valid", 32'(m_valid_out), 32'd0);
    chk("rst_data", 32'(m_data_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_frames", 32'(frame_count_out), 32'd0);

    rdy_mode = 0;
    repeat (1000) begin
      tick();
      chk("quiet", 32'({fifo_read_out, m_valid_out, busy_out}), 32'd0);
    end

    w = '{8'h11, 8'h22, 8'h33};
    meas = 1;
    push_words(w);
    model_burst(w);
    wait_done("s1");
    chk("s1_gap", 32'(sof_gap), 32'(TIMEOUT + 1));

    w.delete();
    for (int i = 1; i <= 16; i++) w.push_back(8'(i));
    w.push_back(8'h55);
    meas = 1;
    push_words(w);
    model_burst(w);
    wait_done("s2");
    chk("s2_gap", 32'(sof_gap), 32'd2);
    chk("s2_fifo", 32'(fifo_at_sof), 32'd1);

    rdy_mode = 1;
    w = '{8'h11, 8'h22, 8'h33};
    meas = 1;
    push_words(w);
    model_burst(w);
    wait_done("s3");
    chk("s3_gap", 32'(sof_gap), 32'(TIMEOUT + 1));

    for (int it = 0; it < 6; it++) begin
      if (it < 2) begin
        rdy_mode = 0;
        a = 8'hAA;
        b = 8'hBB;
        gap = TIMEOUT - 1 + it;
      end else begin
        rdy_mode = 2;
        a = 8'($urandom);
        b = 8'($urandom);
        gap = $urandom_range(TIMEOUT - 3, TIMEOUT + 2);
      end
      if (gap < TIMEOUT) begin
        w = '{a, b};
        model_frame(w);
      end else begin
        w = '{a};
        model_frame(w);
        w = '{b};
        model_frame(w);
      end
      fifo_q.push_back(a);
      tick();
      repeat (gap) tick();
      fifo_q.push_back(b);
      wait_done("gap");
    end

    for (int it = 0; it < 6; it++) begin
      rdy_mode = $urandom_range(0, 2);
      w.delete();
      k = $urandom_range(1, 40);
      for (int i = 0; i < k; i++) w.push_back(8'($urandom));
      push_words(w);
      model_burst(w);
      wait_done("burst");
    end

    rdy_mode = 0;
    w.delete();
    for (int i = 1; i <= 16; i++) w.push_back(8'(i));
    push_words(w);
    model_burst(w);
    n0 = n_xfer;
    k = 0;
    while (n_xfer < n0 + 6 && k < 200) begin
      tick();
      k++;
    end
    chk("s6_inpay", 32'(n_xfer - n0), 32'd6);
    chk("s6_busy_pre", 32'(busy_out), 32'd1);
    nrst_in = 1'b0;
    #1;
    chk("s6_valid", 32'(m_valid_out), 32'd0);
    chk("s6_busy", 32'(busy_out), 32'd0);
    chk("s6_frames", 32'(frame_count_out), 32'd0);
    chk("s6_read", 32'(fifo_read_out), 32'd0);
    clear_model();
    repeat (3) tick();
    nrst_in = 1'b1;
    w = '{8'h77};
    push_words(w);
    model_burst(w);
    wait_done("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
